// File: rtl/blob_centroid.sv
// blob_centroid: colour-blob tracker. Accumulates coordinates of pixels inside
// a colour window over one frame and divides at frame end to give the centroid.
// Optional: define BBOX_EN to add per-frame bounding box outputs.
module blob_centroid #(
  parameter logic [7:0]  R_MIN     = 8'hC0,
  parameter logic [7:0]  G_MAX     = 8'h40,
  parameter logic [7:0]  B_MAX     = 8'h40,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pixel_in,
  input  logic        pixel_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        vsync,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        found,
  output logic        valid,
  output logic        busy
`ifdef BBOX_EN
  ,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max
`endif
);

  localparam logic [2:0] S_ACCUM = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_DIVX  = 3'd2;
  localparam logic [2:0] S_DIVY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic        match_q, vs_q, vs_p_q;
  logic [10:0] hc_q;
  logic [9:0]  vc_q;
  logic        frame_edge;

  logic [19:0] cnt_q, cnt_d, cnt_b;
  logic [29:0] sx_q, sx_d, sx_b, sy_q, sy_d, sy_b;
  logic [20:0] cnt_add;
  logic [30:0] sx_add, sy_add;

  logic [2:0]  state_q;
  logic [19:0] cnt_s_q, rem_q, rem_nxt;
  logic [29:0] sx_s_q, sy_s_q, qx_q, q_nxt;
  logic [28:0] q_q;
  logic [4:0]  bit_q;
  logic [20:0] trial;
  logic        dvd_msb, ge, div_last, snap;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        found_q;

  // Stage 1: colour match plus coordinates/vsync delayed to stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      vs_q    <= 1'b0;
      vs_p_q  <= 1'b0;
    end else begin
      match_q <= pixel_valid && (pixel_in[23:16] >= R_MIN) &&
                 (pixel_in[15:8] <= G_MAX) && (pixel_in[7:0] <= B_MAX);
      hc_q    <= hcount;
      vc_q    <= vcount;
      vs_q    <= vsync;
      vs_p_q  <= vs_q;
    end
  end

  assign frame_edge = vs_q && !vs_p_q;
  assign snap       = (state_q == S_ACCUM) && frame_edge;
  assign div_last   = (state_q == S_DIVY) && (bit_q == 5'd29);

  // Saturating accumulators; the edge-cycle match seeds the new frame
  always_comb begin
    cnt_b   = frame_edge ? '0 : cnt_q;
    sx_b    = frame_edge ? '0 : sx_q;
    sy_b    = frame_edge ? '0 : sy_q;
    cnt_add = {1'b0, cnt_b} + 21'd1;
    sx_add  = {1'b0, sx_b} + {20'd0, hc_q};
    sy_add  = {1'b0, sy_b} + {21'd0, vc_q};
    cnt_d   = cnt_b;
    sx_d    = sx_b;
    sy_d    = sy_b;
    if (match_q) begin
      cnt_d = cnt_add[20] ? '1 : cnt_add[19:0];
      sx_d  = sx_add[30]  ? '1 : sx_add[29:0];
      sy_d  = sy_add[30]  ? '1 : sy_add[29:0];
    end
  end

  // Accumulator registers run in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
    end
  end

  // One restoring-division step; the dividend MSB shifts out of the snapshot
  always_comb begin
    dvd_msb = (state_q == S_DIVX) ? sx_s_q[29] : sy_s_q[29];
    trial   = {rem_q, dvd_msb};
    ge      = trial >= {1'b0, cnt_s_q};
    rem_nxt = ge ? 20'(trial - {1'b0, cnt_s_q}) : trial[19:0];
    q_nxt   = {q_q, ge};
  end

  // Control FSM, divider and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACCUM;
      cnt_s_q <= '0;
      sx_s_q  <= '0;
      sy_s_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      qx_q    <= '0;
      bit_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      found_q <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: if (frame_edge) begin
          cnt_s_q <= cnt_q;
          sx_s_q  <= sx_q;
          sy_s_q  <= sy_q;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          rem_q <= '0;
          q_q   <= '0;
          bit_q <= '0;
          // cnt=0 always lands here, so the divider never sees a zero divisor
          if (32'(cnt_s_q) < MIN_COUNT) begin
            found_q <= 1'b0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_DIVX;
          end
        end
        S_DIVX: begin
          rem_q  <= rem_nxt;
          q_q    <= q_nxt[28:0];
          sx_s_q <= {sx_s_q[28:0], 1'b0};
          bit_q  <= bit_q + 5'd1;
          if (bit_q == 5'd29) begin
            qx_q    <= q_nxt;
            rem_q   <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            state_q <= S_DIVY;
          end
        end
        S_DIVY: begin
          rem_q  <= rem_nxt;
          q_q    <= q_nxt[28:0];
          sy_s_q <= {sy_s_q[28:0], 1'b0};
          bit_q  <= bit_q + 5'd1;
          if (div_last) begin
            x_q     <= (|qx_q[29:11])  ? 11'h7FF : qx_q[10:0];
            y_q     <= (|q_nxt[29:10]) ? 10'h3FF : q_nxt[9:0];
            found_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_ACCUM;
        default: state_q <= S_ACCUM;
      endcase
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign found = found_q;
  assign valid = (state_q == S_DONE);
  assign busy  = (state_q != S_ACCUM);

`ifdef BBOX_EN
  logic [10:0] xmn_q, xmn_d, xmx_q, xmx_d, xmn_s_q, xmx_s_q, xmn_o_q, xmx_o_q;
  logic [9:0]  ymn_q, ymn_d, ymx_q, ymx_d, ymn_s_q, ymx_s_q, ymn_o_q, ymx_o_q;

  // Running box restarts at each frame edge, like the accumulators
  always_comb begin
    xmn_d = frame_edge ? '1 : xmn_q;
    xmx_d = frame_edge ? '0 : xmx_q;
    ymn_d = frame_edge ? '1 : ymn_q;
    ymx_d = frame_edge ? '0 : ymx_q;
    if (match_q) begin
      if (hc_q < xmn_d) xmn_d = hc_q;
      if (hc_q > xmx_d) xmx_d = hc_q;
      if (vc_q < ymn_d) ymn_d = vc_q;
      if (vc_q > ymx_d) ymx_d = vc_q;
    end
  end

  // Box tracking, snapshot at the edge, publish with a passing result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmn_q <= '1; xmx_q <= '0; ymn_q <= '1; ymx_q <= '0;
      xmn_s_q <= '0; xmx_s_q <= '0; ymn_s_q <= '0; ymx_s_q <= '0;
      xmn_o_q <= '0; xmx_o_q <= '0; ymn_o_q <= '0; ymx_o_q <= '0;
    end else begin
      xmn_q <= xmn_d; xmx_q <= xmx_d; ymn_q <= ymn_d; ymx_q <= ymx_d;
      if (snap) begin
        xmn_s_q <= xmn_q; xmx_s_q <= xmx_q; ymn_s_q <= ymn_q; ymx_s_q <= ymx_q;
      end
      if (div_last) begin
        xmn_o_q <= xmn_s_q; xmx_o_q <= xmx_s_q; ymn_o_q <= ymn_s_q; ymx_o_q <= ymx_s_q;
      end
    end
  end

  assign x_min = xmn_o_q;
  assign x_max = xmx_o_q;
  assign y_min = ymn_o_q;
  assign y_max = ymx_o_q;
`endif

endmodule

// File: tb/tb_blob_centroid.sv
// tb_blob_centroid: directed frames against a frame-level centroid model.
`timescale 1ns/1ps
module tb_blob_centroid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] pixel_in = '0;
  logic        pixel_valid = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        vsync = 1'b0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        found, valid, busy;
`ifdef BBOX_EN
  logic [10:0] x_min, x_max;
  logic [9:0]  y_min, y_max;
`endif

  blob_centroid dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .x(x), .y(y), .found(found), .valid(valid), .busy(busy)
`ifdef BBOX_EN
    , .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, errs = 0;

  // Frame-level model: sums of the current frame, one pending result with
  // its due cycle, the busy window, and the held outputs.
  longint m_cnt = 0, m_sx = 0, m_sy = 0;
  int  pend = 0, pend_cyc = 0, pend_x = 0, pend_y = 0, pend_found = 0;
  int  bs = 1, be = 0;
  int  mx = 0, my = 0, mf = 0;
  int  last_e = 0;
  bit  prev_vs = 0;

  task automatic chk(string nm, longint act, longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A frame ends at cycle e; it is reported only if the block was idle then.
  task automatic frame_end(input int e);
    last_e = e;
    if (!(e >= bs && e <= be)) begin
      pend = 1;
      pend_found = (m_cnt >= 64);
      if (pend_found != 0) begin
        pend_x = int'(m_sx / m_cnt);
        pend_y = int'(m_sy / m_cnt);
        if (pend_x > 2047) pend_x = 2047;
        if (pend_y > 1023) pend_y = 1023;
        pend_cyc = e + 62;
      end else begin
        pend_cyc = e + 2;
      end
      bs = e + 1;
      be = pend_cyc;
    end
    m_cnt = 0; m_sx = 0; m_sy = 0;
  endtask

  task automatic drive(input logic [23:0] p, input logic pv, input int hc, input int vc, input logic vs);
    @(posedge clk); #1;
    pixel_in = p; pixel_valid = pv; hcount = hc[10:0]; vcount = vc[9:0]; vsync = vs;
    if (vs && !prev_vs) frame_end(cyc + 1);
    prev_vs = vs;
    if (pv && p[23:16] >= 8'hC0 && p[15:8] <= 8'h40 && p[7:0] <= 8'h40) begin
      m_cnt++; m_sx += hc; m_sy += vc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(24'h0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic block(input logic [23:0] p, input int x0, input int w, input int y0, input int h);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        drive(p, 1'b1, x0 + i, y0 + j, 1'b0);
  endtask

  // Four cycles: three with vsync high (the first may carry a pixel), one low
  task automatic vs_pulse(input logic [23:0] p, input logic pv, input int hc, input int vc);
    drive(p, pv, hc, vc, 1'b1);
    drive(24'h0, 1'b0, 0, 0, 1'b1);
    drive(24'h0, 1'b0, 0, 0, 1'b1);
    drive(24'h0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    pixel_in = '0; pixel_valid = 1'b0; vsync = 1'b0; prev_vs = 0;
    m_cnt = 0; m_sx = 0; m_sy = 0;
    pend = 0; bs = 1; be = 0; mx = 0; my = 0; mf = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_found", found, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid) begin t = cyc; break; end
    end
    if (t < 0) begin
      vecs++; errs++;
      $display("FAIL wait_valid: no valid within %0d cycles (cycle %0d)", lim, cyc);
    end
  endtask

  // Per-cycle compare of every output against the model
  initial begin
    int ev;
    #2;
    forever begin
      @(negedge clk);
      ev = 0;
      if (pend != 0 && cyc == pend_cyc) begin
        pend = 0; ev = 1; mf = pend_found;
        if (pend_found != 0) begin mx = pend_x; my = pend_y; end
      end
      chk("valid", valid, ev);
      chk("busy", busy, (cyc >= bs && cyc <= be) ? 1 : 0);
      chk("x", x, mx);
      chk("y", y, my);
      chk("found", found, mf);
    end
  end

  initial begin
    int t, e1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("init_busy", busy, 0);
    chk("init_x", x, 0);

    // 1: 10x10 red block; the pixel riding the vsync edge belongs to the next frame
    block(24'hFF0000, 100, 10, 50, 10);
    idle(3);
    vs_pulse(24'hFF0000, 1'b1, 7, 3);
    e1 = last_e;
    wait_valid(100, t);
    chk("t1_lat", t - e1, 62);
    chk("t1_x", x, 104);
    chk("t1_y", y, 54);
    chk("t1_found", found, 1);
`ifdef BBOX_EN
    chk("t1_xmin", x_min, 100);
    chk("t1_xmax", x_max, 109);
    chk("t1_ymin", y_min, 50);
    chk("t1_ymax", y_max, 59);
`endif

    // 2: 4 + 1 carried matches, plus near-miss colours and invalid pixels
    block(24'hFF0000, 20, 4, 30, 1);
    drive(24'hFF0000, 1'b0, 500, 500, 1'b0);
    drive(24'hBF0000, 1'b1, 501, 500, 1'b0);
    drive(24'hFF4100, 1'b1, 502, 500, 1'b0);
    drive(24'hFF0041, 1'b1, 503, 500, 1'b0);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    e1 = last_e;
    wait_valid(20, t);
    chk("t2_lat", t - e1, 2);
    chk("t2_found", found, 0);
    chk("t2_x", x, 104);
    chk("t2_y", y, 54);

    // 3a: exactly MIN_COUNT pixels at the colour-window corner
    repeat (64) drive(24'hC04040, 1'b1, 200, 100, 1'b0);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    e1 = last_e;
    wait_valid(100, t);
    chk("t3a_lat", t - e1, 62);
    chk("t3a_x", x, 200);
    chk("t3a_y", y, 100);
    chk("t3a_found", found, 1);

    // 3b: green one step over the limit
    repeat (64) drive(24'hC04140, 1'b1, 200, 100, 1'b0);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    e1 = last_e;
    wait_valid(20, t);
    chk("t3b_lat", t - e1, 2);
    chk("t3b_found", found, 0);
    chk("t3b_x", x, 200);

    // 4: reset during DIV_X, then repeat case 1
    block(24'hFF0000, 100, 10, 50, 10);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    idle(17);
    do_reset();
    block(24'hFF0000, 100, 10, 50, 10);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    e1 = last_e;
    wait_valid(100, t);
    chk("t4_lat", t - e1, 62);
    chk("t4_x", x, 104);
    chk("t4_y", y, 54);

    // 5: a second frame ends mid-division and is dropped; a third reports
    block(24'hFF0000, 100, 10, 50, 10);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    e1 = last_e;
    block(24'hFF0000, 300, 5, 200, 2);
    idle(6);
    vs_pulse(24'h0, 1'b0, 0, 0);
    chk("t5_gap", last_e - e1, 20);
    wait_valid(100, t);
    chk("t5_lat", t - e1, 62);
    chk("t5_x", x, 104);
    chk("t5_y", y, 54);
    block(24'hFF0000, 10, 8, 20, 8);
    idle(2);
    vs_pulse(24'h0, 1'b0, 0, 0);
    e1 = last_e;
    wait_valid(100, t);
    chk("t5c_lat", t - e1, 62);
    chk("t5c_x", x, 13);
    chk("t5c_y", y, 23);
    chk("t5c_found", found, 1);

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
